dma_rc_h2d_framer: RTL

DMA_RC_H2D_FRAMER -- requirements
Module: dma_rc_h2d_framer

---
 rtl/dma_rc_h2d_framer.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dma_rc_h2d_framer.sv
// dma_rc_h2d_framer
// Frames host-to-device completion data into descriptor-sized packets.
// Each descriptor carries a byte count; input beats are trimmed to that
// count, the final beat is tagged with TLAST, and a completion pulse reports
// the number of bytes forwarded. Input-side TLAST is never consulted.
//
// Optional feature: define DMA_H2D_TIMEOUT_EN to build the idle watchdog,
// which aborts a descriptor after DESCRIPTOR_MAX_TIMEOUT cycles without an
// input handshake and reports it through HW_TIMEOUT.
//
// state  | meaning
// IDLE   | waiting for DESCRIPTOR_START, input not accepted
// STREAM | accepting input beats and trimming them to the remaining size
// FLUSH  | input closed, waiting for the output register to drain

module dma_rc_h2d_framer #(
    parameter int C_BUS_DATA_WIDTH = 256,
    parameter int C_BUS_KEEP_WIDTH = C_BUS_DATA_WIDTH / 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,

    input  logic                        S2C_FIFO_TVALID,
    input  logic [C_BUS_DATA_WIDTH-1:0] S2C_FIFO_TDATA,
    input  logic [C_BUS_KEEP_WIDTH-1:0] S2C_FIFO_TKEEP,
    output logic                        S2C_FIFO_TREADY,

    output logic                        S2C_PROC_TVALID,
    output logic [C_BUS_DATA_WIDTH-1:0] S2C_PROC_TDATA,
    output logic [C_BUS_KEEP_WIDTH-1:0] S2C_PROC_TKEEP,
    output logic                        S2C_PROC_TLAST,
    input  logic                        S2C_PROC_TREADY,

    input  logic                        DESCRIPTOR_START,
    input  logic [63:0]                 CURRENT_DESCRIPTOR_SIZE,
    input  logic [63:0]                 DESCRIPTOR_MAX_TIMEOUT,

    output logic                        HW_DESCRIPTOR_DONE,
    output logic [63:0]                 HW_BYTES_TRANSFERRED,
    output logic                        HW_TIMEOUT
);

    localparam logic [63:0] C_KW64 = 64'(C_BUS_KEEP_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [63:0]                 r_remaining;
    logic [63:0]                 r_bytes;
    logic [63:0]                 r_bytes_xfer;
    logic                        r_done;

    logic                        r_out_valid;
    logic [C_BUS_DATA_WIDTH-1:0] r_out_data;
    logic [C_BUS_KEEP_WIDTH-1:0] r_out_keep;
    logic                        r_out_last;

    logic                        w_drain;
    logic                        w_fifo_tready;
    logic                        w_accept;
    logic                        w_last_beat;
    logic [63:0]                 w_n;
    logic [C_BUS_KEEP_WIDTH-1:0] w_keep_mask;
    logic                        w_load_desc;
    logic                        w_zero_desc;
    logic                        w_finish;
    logic                        w_timeout_hit;

    // Output register can take a new beat when empty or being consumed now.
    assign w_drain       = !r_out_valid || S2C_PROC_TREADY;
    assign w_fifo_tready = (r_state == ST_STREAM) && w_drain;
    assign w_accept      = S2C_FIFO_TVALID && w_fifo_tready;
    assign w_last_beat   = (r_remaining <= C_KW64);
    assign w_n           = w_last_beat ? r_remaining : C_KW64;

    // Low-n-bytes mask: byte i survives while it lies below the remaining count.
    always_comb begin
        w_keep_mask = '0;
        for (int i = 0; i < C_BUS_KEEP_WIDTH; i++) begin
            w_keep_mask[i] = (r_remaining > 64'(i));
        end
    end

`ifdef DMA_H2D_TIMEOUT_EN
    logic [63:0] r_idle_cnt;
    logic [63:0] r_timeout_lim;
    logic        r_aborted;
    logic        r_timeout;

    // A handshake in the same cycle always wins over the watchdog.
    assign w_timeout_hit = (r_state == ST_STREAM) && !w_accept &&
                           (r_timeout_lim != 64'd0) &&
                           ((r_idle_cnt + 64'd1) == r_timeout_lim);

    // Idle watchdog: counts STREAM cycles without an input handshake.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_idle_cnt    <= '0;
            r_timeout_lim <= '0;
            r_aborted     <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= w_finish && r_aborted;
            if (w_load_desc) begin
                r_idle_cnt    <= '0;
                r_timeout_lim <= DESCRIPTOR_MAX_TIMEOUT;
                r_aborted     <= 1'b0;
            end else if (r_state == ST_STREAM) begin
                if (w_accept) begin
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + 64'd1;
                end
                if (w_timeout_hit) begin
                    r_aborted <= 1'b1;
                end
            end
        end
    end

    assign HW_TIMEOUT = r_timeout;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^DESCRIPTOR_MAX_TIMEOUT;
    assign w_timeout_hit    = 1'b0;
    assign HW_TIMEOUT       = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load_desc = 1'b0;
        w_zero_desc = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (DESCRIPTOR_START) begin
                    if (CURRENT_DESCRIPTOR_SIZE != 64'd0) begin
                        w_load_desc = 1'b1;
                        w_state_nxt = ST_STREAM;
                    end else begin
                        w_zero_desc = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (w_accept && w_last_beat) begin
                    w_state_nxt = ST_FLUSH;
                end else if (w_timeout_hit) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_drain) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Descriptor counters and completion reporting.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_remaining  <= '0;
            r_bytes      <= '0;
            r_bytes_xfer <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load_desc) begin
                r_remaining <= CURRENT_DESCRIPTOR_SIZE;
                r_bytes     <= '0;
            end else if (w_accept) begin
                r_remaining <= r_remaining - w_n;
                r_bytes     <= r_bytes + w_n;
            end
            if (w_zero_desc) begin
                r_done       <= 1'b1;
                r_bytes_xfer <= '0;
            end else if (w_finish) begin
                r_done       <= 1'b1;
                r_bytes_xfer <= r_bytes;
            end
        end
    end

    // Single output register stage; holds its beat while the sink stalls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= S2C_FIFO_TDATA;
                r_out_keep  <= S2C_FIFO_TKEEP & w_keep_mask;
                r_out_last  <= w_last_beat;
            end else if (S2C_PROC_TREADY) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign S2C_FIFO_TREADY      = w_fifo_tready;
    assign S2C_PROC_TVALID      = r_out_valid;
    assign S2C_PROC_TDATA       = r_out_data;
    assign S2C_PROC_TKEEP       = r_out_keep;
    assign S2C_PROC_TLAST       = r_out_last;
    assign HW_DESCRIPTOR_DONE   = r_done;
    assign HW_BYTES_TRANSFERRED = r_bytes_xfer;

endmodule
